// File: rtl/domino_adder_ctrl_if.sv
// Requester/adder bus for the domino adder controller: two requester ports,
// the adder drive/sense pins and the captured result.
interface domino_adder_ctrl_if #(
  parameter int N = 8
);
  logic         req0;
  logic [N-1:0] a0;
  logic [N-1:0] b0;
  logic         sub0;
  logic         req1;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
  logic         sub1;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic         busy;
  logic [N-1:0] addA;
  logic [N-1:0] addB;
  logic         addSub;
  logic         addEval;
  logic [N-1:0] addS;
  logic         addCout;
  logic [N-1:0] res;
  logic         resCout;
  logic         resOvf;

  modport slave (
    input  req0, a0, b0, sub0, req1, a1, b1, sub1, addS, addCout,
    output gnt0, gnt1, done0, done1, busy, addA, addB, addSub, addEval,
           res, resCout, resOvf
  );

  modport master (
    output req0, a0, b0, sub0, req1, a1, b1, sub1, addS, addCout,
    input  gnt0, gnt1, done0, done1, busy, addA, addB, addSub, addEval,
           res, resCout, resOvf
  );
endinterface

// File: rtl/domino_adder_ctrl.sv
// Round-robin sequencer for a domino adder: grants one of two requesters,
// walks the adder through precharge/evaluate and captures the result.
module domino_adder_ctrl #(
  parameter int N           = 8,
  parameter int PRE_CYCLES  = 1,
  parameter int EVAL_CYCLES = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  domino_adder_ctrl_if.slave bus
);
  localparam int MAXC = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           owner_q, owner_d;
  logic           ptr_q, ptr_d;
  logic [N-1:0]   addA_q, addA_d;
  logic [N-1:0]   addB_q, addB_d;
  logic           addSub_q, addSub_d;
  logic [N-1:0]   res_q, res_d;
  logic           resCout_q, resCout_d;
  logic           resOvf_q, resOvf_d;
  logic           pick;
  logic           sA, sB, sS;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    addA_d    = addA_q;
    addB_d    = addB_q;
    addSub_d  = addSub_q;
    res_d     = res_q;
    resCout_d = resCout_q;
    resOvf_d  = resOvf_q;
    pick      = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
    sA        = addA_q[N-1];
    sB        = addB_q[N-1];
    sS        = bus.addS[N-1];
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d  = pick;
          addA_d   = pick ? bus.a1 : bus.a0;
          addB_d   = pick ? bus.b1 : bus.b0;
          addSub_d = pick ? bus.sub1 : bus.sub0;
          cnt_d    = CW'(PRE_CYCLES - 1);
          state_d  = PRE;
        end
      end
      PRE: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(EVAL_CYCLES - 1);
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      EVAL: begin
        // The sum is only trusted on the last evaluate edge; precharge reads all-ones.
        if (cnt_q == '0) begin
          res_d     = bus.addS;
          resCout_d = bus.addCout;
          resOvf_d  = addSub_q ? ((sA != sB) && (sS != sA))
                               : ((sA == sB) && (sS != sA));
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        ptr_d   = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      addA_q    <= '0;
      addB_q    <= '0;
      addSub_q  <= 1'b0;
      res_q     <= '0;
      resCout_q <= 1'b0;
      resOvf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      addA_q    <= addA_d;
      addB_q    <= addB_d;
      addSub_q  <= addSub_d;
      res_q     <= res_d;
      resCout_q <= resCout_d;
      resOvf_q  <= resOvf_d;
    end
  end

  assign bus.gnt0    = (state_q != IDLE) && !owner_q;
  assign bus.gnt1    = (state_q != IDLE) && owner_q;
  assign bus.done0   = (state_q == DONE) && !owner_q;
  assign bus.done1   = (state_q == DONE) && owner_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.addEval = (state_q == EVAL);
  assign bus.addA    = addA_q;
  assign bus.addB    = addB_q;
  assign bus.addSub  = addSub_q;
  assign bus.res     = res_q;
  assign bus.resCout = resCout_q;
  assign bus.resOvf  = resOvf_q;
endmodule

// File: tb/tb_domino_adder_ctrl.sv
// Scoreboard bench for domino_adder_ctrl: directed operations on a default
// instance and a PRE_CYCLES=2/EVAL_CYCLES=3 instance, each with a domino adder model.
module tb_domino_adder_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic watchGnt1 = 1'b0;
  logic gnt1Seen  = 1'b0;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];

  domino_adder_ctrl_if #(.N(8)) bus1 ();
  domino_adder_ctrl_if #(.N(8)) bus2 ();

  domino_adder_ctrl #(.N(8), .PRE_CYCLES(1), .EVAL_CYCLES(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );
  domino_adder_ctrl #(.N(8), .PRE_CYCLES(2), .EVAL_CYCLES(3)) dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Domino adder model: all-ones during precharge, A +/- B while evaluating.
  function automatic logic [8:0] adderModel(logic ev, logic sub, logic [7:0] a, logic [7:0] b);
    if (!ev) return 9'h1FF;
    if (sub) return {1'b0, a} + {1'b0, ~b} + 9'd1;
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign {bus1.addCout, bus1.addS} = adderModel(bus1.addEval, bus1.addSub, bus1.addA, bus1.addB);
  assign {bus2.addCout, bus2.addS} = adderModel(bus2.addEval, bus2.addSub, bus2.addA, bus2.addB);

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitorDone(input int inst, input logic d0, input logic d1, input logic g0,
                             input logic g1, input logic [7:0] res, input logic cout,
                             input logic ovf);
    exp_t e;
    if (d0 || d1) begin
      checkOutput("done_exclusive", int'(d0 && d1), 0);
      checkOutput("gnt_exclusive", int'(g0 && g1), 0);
      if ((inst == 1 && sb1.size() == 0) || (inst == 2 && sb2.size() == 0)) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = (inst == 1) ? sb1.pop_front() : sb2.pop_front();
        checkOutput("done_owner", int'(d1), e.id);
        checkOutput("done_cycle", cyc, e.cyc);
        checkOutput("res", int'(res), int'(e.res));
        checkOutput("res_cout", int'(cout), int'(e.cout));
        checkOutput("res_ovf", int'(ovf), int'(e.ovf));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      monitorDone(1, bus1.done0, bus1.done1, bus1.gnt0, bus1.gnt1, bus1.res, bus1.resCout, bus1.resOvf);
      monitorDone(2, bus2.done0, bus2.done1, bus2.gnt0, bus2.gnt1, bus2.res, bus2.resCout, bus2.resOvf);
      if (watchGnt1 && bus1.gnt1) gnt1Seen = 1'b1;
    end
  end

  task automatic pushExp(input int inst, input int id, input logic [7:0] res, input logic cout,
                         input logic ovf, input int doneCyc);
    exp_t e;
    e.id = id; e.res = res; e.cout = cout; e.ovf = ovf; e.cyc = doneCyc;
    if (inst == 1) sb1.push_back(e);
    else sb2.push_back(e);
  endtask

  task automatic waitDone(input int id, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(id == 1 ? bus1.done1 : bus1.done0) && n < limit);
    if (!(id == 1 ? bus1.done1 : bus1.done0)) checkOutput("done_timeout", 0, 1);
  endtask

  // Requester behaviour: hold request and operands until its done pulse.
  task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b,
                               input logic sub);
    if (id == 0) begin
      bus1.a0 = a; bus1.b0 = b; bus1.sub0 = sub; bus1.req0 = 1'b1;
    end else begin
      bus1.a1 = a; bus1.b1 = b; bus1.sub1 = sub; bus1.req1 = 1'b1;
    end
    waitDone(id, 40);
    if (id == 0) bus1.req0 = 1'b0;
    else bus1.req1 = 1'b0;
  endtask

  initial begin
    int c0;
    int pat[4] = '{0, 1, 1, 0};
    bus1.req0 = 0; bus1.req1 = 0; bus1.a0 = 0; bus1.b0 = 0; bus1.sub0 = 0;
    bus1.a1 = 0; bus1.b1 = 0; bus1.sub1 = 0;
    bus2.req0 = 0; bus2.req1 = 0; bus2.a0 = 0; bus2.b0 = 0; bus2.sub0 = 0;
    bus2.a1 = 0; bus2.b1 = 0; bus2.sub1 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", int'(bus1.busy), 0);
    checkOutput("reset_eval", int'(bus1.addEval), 0);
    checkOutput("reset_res", int'(bus1.res), 0);
    checkOutput("reset_gnt0", int'(bus1.gnt0), 0);
    checkOutput("reset_add_a", int'(bus1.addA), 0);
    @(negedge clk);

    // Single add with signed overflow; requester 1 must stay ungranted.
    watchGnt1 = 1'b1;
    pushExp(1, 0, 8'h80, 1'b0, 1'b1, cyc + 4);
    applyStimulus(0, 8'h7F, 8'h01, 1'b0);
    watchGnt1 = 1'b0;
    checkOutput("single_gnt1", int'(gnt1Seen), 0);
    @(negedge clk);

    // Zero plus zero: a precharge sample would show 0xFF.
    c0 = cyc;
    pushExp(1, 0, 8'h00, 1'b0, 1'b0, c0 + 4);
    bus1.a0 = 8'h00; bus1.b0 = 8'h00; bus1.sub0 = 1'b0; bus1.req0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("eval_wave", int'(bus1.addEval), pat[k]);
    end
    bus1.req0 = 1'b0;
    @(negedge clk);

    pushExp(1, 1, 8'hFE, 1'b0, 1'b0, cyc + 4);
    applyStimulus(1, 8'h05, 8'h07, 1'b1);
    @(negedge clk);
    pushExp(1, 1, 8'h7F, 1'b1, 1'b1, cyc + 4);
    applyStimulus(1, 8'h80, 8'h01, 1'b1);
    @(negedge clk);
    pushExp(1, 0, 8'h30, 1'b0, 1'b0, cyc + 4);
    applyStimulus(0, 8'h10, 8'h20, 1'b0);
    @(negedge clk);

    // Abort during evaluate; the pointer currently favours requester 1.
    bus1.a0 = 8'h11; bus1.b0 = 8'h22; bus1.sub0 = 1'b0; bus1.req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_in_eval", int'(bus1.addEval), 1);
    rst = 1'b1;
    bus1.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", int'(bus1.busy), 0);
    checkOutput("abort_eval", int'(bus1.addEval), 0);
    checkOutput("abort_res", int'(bus1.res), 0);
    checkOutput("abort_done0", int'(bus1.done0), 0);
    repeat (6) @(negedge clk);

    // Both requesters held: alternation starting at requester 0, 5 cycles apart.
    c0 = cyc;
    pushExp(1, 0, 8'h03, 1'b0, 1'b0, c0 + 4);
    pushExp(1, 1, 8'h0F, 1'b1, 1'b0, c0 + 9);
    pushExp(1, 0, 8'h00, 1'b1, 1'b0, c0 + 14);
    pushExp(1, 1, 8'h80, 1'b0, 1'b1, c0 + 19);
    fork
      begin
        applyStimulus(0, 8'h01, 8'h02, 1'b0);
        applyStimulus(0, 8'hFF, 8'h01, 1'b0);
      end
      begin
        applyStimulus(1, 8'h10, 8'h01, 1'b1);
        applyStimulus(1, 8'h40, 8'h40, 1'b0);
      end
    join
    repeat (2) @(negedge clk);

    // Longer phases; the request drops in cycle 2 and must still complete.
    c0 = cyc;
    pushExp(2, 0, 8'h30, 1'b0, 1'b0, c0 + 6);
    bus2.a0 = 8'h10; bus2.b0 = 8'h20; bus2.sub0 = 1'b0; bus2.req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus2.req0 = 1'b0;
    for (int k = 0; k < 20 && !bus2.done0; k++) @(negedge clk);
    if (!bus2.done0) checkOutput("done_timeout_p", 0, 1);
    repeat (3) @(negedge clk);

    checkOutput("sb1_empty", sb1.size(), 0);
    checkOutput("sb2_empty", sb2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/domino_adder_ctrl.md
Name: domino_adder_ctrl

Overview:
Sequencer and two-port round-robin arbiter for the N-bit domino SPG adder datapath. It accepts add/subtract requests from two requesters and latches the granted operands and Sub control into the adder. It steps the adder through precharge and evaluate phases, captures sum, carry-out and signed overflow, and returns a one-cycle done pulse to the granted requester.

Parameters:
N, 8, operand/result width
PRE_CYCLES, 1, precharge cycles per operation (>=1)
EVAL_CYCLES, 2, evaluate cycles before capture (>=1)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous active-high reset
REQ0  input  1  requester 0 request; held until DONE0
A0  input  N  requester 0 operand A
B0  input  N  requester 0 operand B
SUB0  input  1  requester 0 op (1 = A-B, 0 = A+B)
REQ1, A1, B1, SUB1  input  1/N/N/1  requester 1 equivalents
GNT0  output  1  requester 0 owns adder (PRE through DONE states)
GNT1  output  1  requester 1 owns adder
ADD_A  output  N  registered operand A to adder
ADD_B  output  N  registered operand B to adder
ADD_SUB  output  1  registered Sub control to adder
ADD_EVAL  output  1  domino phase enable: 0 = precharge, 1 = evaluate
ADD_S  input  N  adder sum; reads all-ones during precharge
ADD_COUT  input  1  adder carry-out
RES  output  N  captured result
RES_COUT  output  1  captured carry-out (sub: 1 = no borrow)
RES_OVF  output  1  captured signed overflow
DONE0  output  1  one-cycle completion pulse, requester 0
DONE1  output  1  one-cycle completion pulse, requester 1
BUSY  output  1  state != IDLE

Behaviour:
- Reset (RST high at a rising edge): state=IDLE; all outputs 0, including ADD_EVAL=0; priority pointer set to requester 0. Applies mid-operation: no DONE for the aborted operation, RES cleared.
- States: IDLE -> PRE -> EVAL -> DONE -> IDLE.
- IDLE:
  - REQx sampled here only.
  - If exactly one REQ is high, grant that requester.
  - If both are high, grant the pointer's requester.
  - On the grant edge, latch Ax/Bx/SUBx into ADD_A/ADD_B/ADD_SUB, assert GNTx, go to PRE.
  - No request: stay in IDLE; ADD_* hold their last values.
- PRE: ADD_EVAL=0 for PRE_CYCLES cycles (down-counter), then EVAL.
- EVAL: ADD_EVAL=1 for EVAL_CYCLES cycles.
  - On the edge ending the last EVAL cycle: RES<=ADD_S, RES_COUT<=ADD_COUT, RES_OVF computed; go to DONE.
  - ADD_S is never sampled while ADD_EVAL=0.
- DONE: DONEx=1 for exactly one cycle; ADD_EVAL=0; GNTx still 1. Pointer moves to the other requester. Next state IDLE, GNT drops.
- Overflow, with s=ADD_S[N-1], a=ADD_A[N-1], b=ADD_B[N-1]:
  - Add: OVF = (a==b) && (s!=a).
  - Sub: OVF = (a!=b) && (s!=a).
- RES/RES_COUT/RES_OVF hold until the next capture or reset.
- Latency: request seen in IDLE at cycle 0 -> DONE at cycle PRE_CYCLES+EVAL_CYCLES+1 (defaults: cycle 4). Throughput is one operation per PRE+EVAL+2 cycles.
- Handshake:
  - Requester holds REQx and its operands until it sees DONEx.
  - It deasserts REQx in the cycle after DONEx unless it issues a new operation.
  - Operands change after the grant edge are ignored.
  - REQx dropping mid-operation does not abort; DONEx still pulses.
- Round robin: after DONE0 with both requesting, requester 1 wins the next IDLE, and vice versa. A lone requester is granted back-to-back regardless of the pointer.
- DONE0 and DONE1 are never high together; GNT0 and GNT1 are never high together.

Test Plan:
- Bench adder model for all scenarios: ADD_S/ADD_COUT = all ones while ADD_EVAL=0; otherwise ADD_A +/- ADD_B per ADD_SUB.
- Single add: REQ0, A0=0x7F, B0=0x01, SUB0=0 -> DONE0 at cycle 4; RES=0x80, RES_OVF=1, RES_COUT=0; GNT1 never high.
- Subtract: REQ1, A1=0x05, B1=0x07, SUB1=1 -> RES=0xFE, RES_COUT=0, RES_OVF=0. Repeat with A1=0x80, B1=0x01 -> RES=0x7F, RES_OVF=1, RES_COUT=1.
- Arbitration: REQ0 and REQ1 held high from reset for 4 operations -> grant order 0,1,0,1. DONE pulses spaced 5 cycles apart; never simultaneous.
- Precharge isolation: A=0x00, B=0x00 add -> RES=0x00, never 0xFF. ADD_EVAL waveform is 0 (1 cycle), 1 (2 cycles), 0 (DONE).
- Reset mid-EVAL: assert RST for 1 cycle during EVAL -> next cycle BUSY=0, ADD_EVAL=0, RES=0, no DONE. The following request is granted to requester 0.
- Parameters PRE_CYCLES=2, EVAL_CYCLES=3: REQ0 A0=0x10, B0=0x20 -> DONE0 exactly at cycle 6, RES=0x30; REQ0 dropped in cycle 2 still completes.
